// File: rtl/wr_drain_ctrl_if.sv
// Shared 64-bit data-memory port between the writeback drain controller and memory.
// The controller drives the request side (master); memory answers with mem_ack (slave).
interface wr_drain_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack
    );
endinterface

// File: rtl/wr_drain_ctrl.sv
// Drains the store write FIFO into the shared memory port, splitting 8-byte-crossing stores
// and arbitrating against loads. Optional drain-starvation timeout: define DRAIN_TIMEOUT_EN.
module wr_drain_ctrl #(
    parameter int DATA_W       = 98,
    parameter int STARVE_LIMIT = 8,
    parameter int STARVE_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    output logic              ld_ack,
    wr_drain_ctrl_if.master   bus,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WR1, WR2, LD} state_t;

    state_t      state;
    logic [63:0] head_data;
    logic [31:0] head_addr;
    logic [1:0]  head_size;
    logic [2:0]  off;
    logic [3:0]  nb;
    logic [15:0] mask;
    logic        split;
    logic [5:0]  sh_lo;
    logic [6:0]  sh_hi;
    logic [63:0] wdata_lo;
    logic [63:0] wdata_hi;
    logic [31:0] addr_lo;
    logic [31:0] addr_hi;
    logic        ack;
    logic        starve_hit;
    logic        pick_wr;
    logic        pick_ld;

    if ((STARVE_LIMIT >= (1 << STARVE_W)) || (DATA_W < 98)) begin : g_param_check
        $error("wr_drain_ctrl: STARVE_W cannot hold STARVE_LIMIT or DATA_W below 98");
    end

    assign head_data = fifo_rd_data[34 +: 64];
    assign head_addr = fifo_rd_data[2 +: 32];
    assign head_size = fifo_rd_data[1:0];
    assign off       = head_addr[2:0];
    assign nb        = 4'd1 << head_size;
    assign mask      = ((16'd1 << nb) - 16'd1) << off;
    assign split     = |mask[15:8];

    // Second beat only exists when off != 0, so the 64-off*8 shift never reaches 64 in use.
    assign sh_lo     = {off, 3'b000};
    assign sh_hi     = 7'd64 - {1'b0, sh_lo};
    assign wdata_lo  = head_data << sh_lo;
    assign wdata_hi  = head_data >> sh_hi;
    assign addr_lo   = {head_addr[31:3], 3'b000};
    assign addr_hi   = {head_addr[31:3] + 29'd1, 3'b000};

    assign ack     = bus.mem_req & bus.mem_ack;
    assign pick_wr = fifo_full || (!fifo_empty && (!ld_req || starve_hit));
    assign pick_ld = !pick_wr && ld_req;

    assign busy    = (state != IDLE);
    assign fifo_rd = ack && (((state == WR1) && !split) || (state == WR2));
    assign ld_ack  = ack && (state == LD);

`ifdef DRAIN_TIMEOUT_EN
    logic [STARVE_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Counts arbitrations a pending store lost to a load; any drain start or empty FIFO clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_wr)
                starve_cnt <= '0;
            else if (pick_ld)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_wr) begin
                        state         <= WR1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= addr_lo;
                        bus.mem_wdata <= wdata_lo;
                        bus.mem_be    <= mask[7:0];
                    end else if (pick_ld) begin
                        state         <= LD;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= ld_addr;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= '0;
                    end
                end
                WR1: begin
                    if (ack) begin
                        if (split) begin
                            // Back-to-back second beat; the head is not popped yet.
                            state         <= WR2;
                            bus.mem_addr  <= addr_hi;
                            bus.mem_wdata <= wdata_hi;
                            bus.mem_be    <= mask[15:8];
                        end else begin
                            state       <= IDLE;
                            bus.mem_req <= 1'b0;
                        end
                    end
                end
                WR2, LD: begin
                    if (ack) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
